// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, word-wide data memory between the
// instruction-fetch port and the load/store port of an RV32I core.
// Round-robin arbitration on a last-grant bit; one access in flight at a time.
// Handles lb/lh/lw/lbu/lhu and sb/sh/sw, including sign and zero extension.
//
// Optional feature macro: MEM_ARB_MISALIGN_EN
//   defined   : misaligned accesses are split into word W then W+1 (ACC1 state)
//   undefined : misaligned accesses complete with ls_err=1 and no memory access
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request, held until if_ready
//   if_ready/if_rdata             one-cycle completion pulse, instruction word
//   ls_req/ls_we/ls_funct3/
//   ls_addr/ls_wdata              load/store request, held until ls_ready
//   ls_ready/ls_rdata/ls_err      one-cycle completion pulse, extended data, error
//   mem_en/mem_we/mem_addr/
//   mem_wstrb/mem_wdata           registered memory command (word address)
//   mem_rdata                     synchronous read data, valid cycle after mem_en
module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WA = ADDR_W - 2;
  localparam logic [WA-1:0] WORD_ONE = WA'(1);

  typedef struct packed {
    logic              is_ls;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    RESP = 2'd2
`ifdef MEM_ARB_MISALIGN_EN
    , ACC1 = 2'd3
`endif
  } state_t;

  state_t state;
  logic   last_grant;   // 0 = fetch granted last, 1 = LSU granted last
  cmd_t   cmd_q, cmd_in, cmd_sel;

  // fetch word address only; the low bits are don't-care by contract
  logic unused_ok;
  assign unused_ok = ^if_addr[1:0];

  // ---- arbitration ----
  logic grant_any, grant_ls;
  assign grant_any = if_req | ls_req;
  assign grant_ls  = ls_req & (~if_req | ~last_grant);

  always_comb begin
    cmd_in = '0;
    if (grant_ls) begin
      cmd_in.is_ls  = 1'b1;
      cmd_in.we     = ls_we;
      cmd_in.funct3 = ls_funct3;
      cmd_in.addr   = ls_addr;
      cmd_in.wdata  = ls_wdata;
    end else begin
      // a fetch is just an aligned word load
      cmd_in.funct3 = 3'b010;
      cmd_in.addr   = {if_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // decode the incoming command in IDLE, the captured one afterwards
  assign cmd_sel = (state == IDLE) ? cmd_in : cmd_q;

  // ---- decode ----
  logic [1:0] off;
  logic       legal, misal, split, err;
  assign off = cmd_sel.addr[1:0];

  always_comb begin
    legal = 1'b0;
    if (cmd_sel.we) begin
      legal = (cmd_sel.funct3 == 3'b000) | (cmd_sel.funct3 == 3'b001) |
              (cmd_sel.funct3 == 3'b010);
    end else begin
      case (cmd_sel.funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

  assign misal = ((cmd_sel.funct3[1:0] == 2'b01) && (off == 2'b11)) ||
                 ((cmd_sel.funct3[1:0] == 2'b10) && (off != 2'b00));

`ifdef MEM_ARB_MISALIGN_EN
  assign split = legal & misal;
  assign err   = cmd_sel.is_ls & ~legal;
`else
  assign split = 1'b0;
  assign err   = cmd_sel.is_ls & (~legal | misal);
`endif

  // ---- store formatting: 8-lane mask/data, beat 0 low half, beat 1 high ----
  logic [3:0]  base;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        hi_beat;
  logic [3:0]  strb_beat;
  logic [31:0] wdata_beat;

  always_comb begin
    case (cmd_sel.funct3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
  end

  assign mask8      = cmd_sel.we ? ({4'b0000, base} << off) : 8'h00;
  assign data64     = cmd_sel.we ? ({32'h0, cmd_sel.wdata} << {off, 3'b000}) : 64'h0;
  // the only registered command issued from ACC0 is the second beat
  assign hi_beat    = (state == ACC0);
  assign strb_beat  = hi_beat ? mask8[7:4]    : mask8[3:0];
  assign wdata_beat = hi_beat ? data64[63:32] : data64[31:0];

  // ---- load formatting: byte stream starting at lane off ----
  logic [63:0] stream;
  logic [31:0] ld_word, ld_ext;

`ifdef MEM_ARB_MISALIGN_EN
  logic [31:0] beat0_q;
  assign stream = split ? {mem_rdata, beat0_q} : {32'h0, mem_rdata};
`else
  assign stream = {32'h0, mem_rdata};
`endif

  assign ld_word = 32'(stream >> {cmd_q.addr[1:0], 3'b000});

  always_comb begin
    case (cmd_q.funct3)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign ls_rdata = (ls_ready & ~ls_err & ~cmd_q.we) ? ld_ext : 32'h0;
  assign if_rdata = if_ready ? mem_rdata : 32'h0;

  // ---- FSM with registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      cmd_q      <= '0;
      if_ready   <= 1'b0;
      ls_ready   <= 1'b0;
      ls_err     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'h0;
      mem_wdata  <= 32'h0;
`ifdef MEM_ARB_MISALIGN_EN
      beat0_q    <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cmd_q      <= cmd_in;
            last_grant <= grant_ls;
            if (err) begin
              // rejected before touching memory
              state    <= RESP;
              ls_ready <= 1'b1;
              ls_err   <= 1'b1;
            end else begin
              state     <= ACC0;
              mem_en    <= 1'b1;
              mem_we    <= cmd_in.we;
              mem_addr  <= cmd_in.addr[ADDR_W-1:2];
              mem_wstrb <= strb_beat;
              mem_wdata <= wdata_beat;
            end
          end
        end
        ACC0: begin
          if (split) begin
`ifdef MEM_ARB_MISALIGN_EN
            state     <= ACC1;
            mem_addr  <= cmd_q.addr[ADDR_W-1:2] + WORD_ONE;  // wraps at top word
            mem_wstrb <= strb_beat;
            mem_wdata <= wdata_beat;
`endif
          end else begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            if (cmd_q.is_ls) ls_ready <= 1'b1;
            else             if_ready <= 1'b1;
          end
        end
`ifdef MEM_ARB_MISALIGN_EN
        ACC1: begin
          beat0_q   <= mem_rdata;
          state     <= RESP;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wstrb <= 4'h0;
          mem_wdata <= 32'h0;
          ls_ready  <= 1'b1;
        end
`endif
        RESP: begin
          state    <= IDLE;
          if_ready <= 1'b0;
          ls_ready <= 1'b0;
          ls_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
